// File: rtl/test_seq_analyzer.sv
// test_seq_analyzer: multi-channel test sequencer and response checker.
// Plays stored stimulus vectors to a DUT path, waits for the response with a
// bounded timeout, compares NUM_CH response channels against per-vector
// expected values under a channel mask, and keeps saturating error, timeout
// and latency statistics.
// Optional build macro: TSA_STOP_ON_FAIL_EN -- the first mismatch or timeout
// ends the run (the failing vector is still counted in vec_cnt).
module test_seq_analyzer #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  vec_wr_en,
    input  logic [AW-1:0]                         vec_wr_addr,
    input  logic [DATA_W+NUM_CH*DATA_W+NUM_CH-1:0] vec_wr_data,
    input  logic                                  start,
    input  logic [AW:0]                           num_vec,
    input  logic                                  abort,
    output logic [DATA_W-1:0]                     stim_out,
    output logic                                  stim_valid,
    input  logic [NUM_CH*DATA_W-1:0]              resp_data,
    input  logic                                  resp_valid,
    output logic                                  busy,
    output logic                                  done,
    output logic [NUM_CH*CNT_W-1:0]               err_cnt,
    output logic [CNT_W-1:0]                      timeout_cnt,
    output logic [AW:0]                           vec_cnt,
    output logic [CNT_W-1:0]                      lat_min,
    output logic [CNT_W-1:0]                      lat_max,
    output logic [31:0]                           lat_sum,
    output logic                                  fail_valid,
    output logic [AW-1:0]                         fail_addr
);

    localparam int WORD_W = DATA_W + NUM_CH * DATA_W + NUM_CH;
    localparam int EXP_LO = DATA_W;
    localparam int MSK_LO = DATA_W + NUM_CH * DATA_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRIVE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Vector store; no reset so it maps onto block RAM.
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_word;

    logic [2:0]                 state;
    logic [AW-1:0]              addr;
    logic [AW:0]                run_len;
    logic [CNT_W-1:0]           lat;
    logic [CNT_W-1:0]           lat_cap;
    logic [NUM_CH*DATA_W-1:0]   resp_cap;
    logic                       timed_out;

    logic                       run_start;
    logic                       check_fire;
    logic [NUM_CH-1:0]          mismatch;
    logic                       cmp_fail;
    logic [AW:0]                vec_next;
    logic                       run_end;
    logic [AW:0]                len_clamped;
    logic [32:0]                lat_sum_ext;

    // A run is accepted only from IDLE; abort takes priority over start.
    assign run_start  = (state == S_IDLE) && start && !abort;
    // CHECK updates are suppressed if the run is being aborted in that cycle.
    assign check_fire = (state == S_CHECK) && !abort;

    // Requests beyond the memory size run the whole memory once.
    assign len_clamped = (num_vec > (AW + 1)'(DEPTH)) ? (AW + 1)'(DEPTH) : num_vec;

    assign vec_next    = vec_cnt + (AW + 1)'(1);
    assign lat_sum_ext = {1'b0, lat_sum} + 33'(lat_cap);

    // A timed-out vector has no captured response, so it never compares.
    assign cmp_fail = !timed_out && (|mismatch);

`ifdef TSA_STOP_ON_FAIL_EN
    assign run_end = (vec_next == run_len) || timed_out || cmp_fail;
`else
    assign run_end = (vec_next == run_len);
`endif

    // Vector memory: writes only while no run is active; read issued in FETCH.
    always_ff @(posedge clk) begin
        if (vec_wr_en && !busy) begin
            mem[vec_wr_addr] <= vec_wr_data;
        end
        if (state == S_FETCH) begin
            rd_word <= mem[addr];
        end
    end

    // Per-channel compare and saturating error counter.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] exp_word;
            logic [DATA_W-1:0] resp_word;
            logic              mask_bit;
            logic [CNT_W-1:0]  err_q;

            assign exp_word     = rd_word[EXP_LO + gi * DATA_W +: DATA_W];
            assign resp_word    = resp_cap[gi * DATA_W +: DATA_W];
            assign mask_bit     = rd_word[MSK_LO + gi];
            assign mismatch[gi] = mask_bit && (exp_word != resp_word);

            // Count enabled-channel mismatches, holding at all-ones.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    err_q <= '0;
                end else if (run_start) begin
                    err_q <= '0;
                end else if (check_fire && !timed_out && mismatch[gi] && (err_q != '1)) begin
                    err_q <= err_q + 1'b1;
                end
            end

            assign err_cnt[gi * CNT_W +: CNT_W] = err_q;
        end
    endgenerate

    // Sequencer FSM with run statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            run_len     <= '0;
            lat         <= '0;
            lat_cap     <= '0;
            resp_cap    <= '0;
            timed_out   <= 1'b0;
            stim_out    <= '0;
            stim_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_cnt <= '0;
            vec_cnt     <= '0;
            lat_min     <= '1;
            lat_max     <= '0;
            lat_sum     <= '0;
            fail_valid  <= 1'b0;
            fail_addr   <= '0;
        end else begin
            done       <= 1'b0;
            stim_valid <= 1'b0;
            if ((state != S_IDLE) && abort) begin
                // Abandon the run; statistics are left as they stand.
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run_start) begin
                            busy        <= 1'b1;
                            addr        <= '0;
                            run_len     <= len_clamped;
                            timeout_cnt <= '0;
                            vec_cnt     <= '0;
                            lat_min     <= '1;
                            lat_max     <= '0;
                            lat_sum     <= '0;
                            fail_valid  <= 1'b0;
                            fail_addr   <= '0;
                            state       <= (num_vec == '0) ? S_DONE : S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state <= S_DRIVE;
                    end
                    S_DRIVE: begin
                        stim_out   <= rd_word[DATA_W-1:0];
                        stim_valid <= 1'b1;
                        lat        <= '0;
                        state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        // lat counts cycles since the stim_valid cycle.
                        if (resp_valid) begin
                            resp_cap  <= resp_data;
                            lat_cap   <= lat;
                            timed_out <= 1'b0;
                            state     <= S_CHECK;
                        end else if (lat == CNT_W'(TIMEOUT)) begin
                            timed_out <= 1'b1;
                            if (timeout_cnt != '1) begin
                                timeout_cnt <= timeout_cnt + 1'b1;
                            end
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                fail_addr  <= addr;
                            end
                            state <= S_CHECK;
                        end else begin
                            lat <= lat + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (!timed_out) begin
                            if (lat_cap < lat_min) begin
                                lat_min <= lat_cap;
                            end
                            if (lat_cap > lat_max) begin
                                lat_max <= lat_cap;
                            end
                            lat_sum <= lat_sum_ext[32] ? 32'hFFFF_FFFF : lat_sum_ext[31:0];
                        end
                        if (cmp_fail && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_addr  <= addr;
                        end
                        vec_cnt <= vec_next;
                        addr    <= addr + 1'b1;
                        state   <= run_end ? S_DONE : S_FETCH;
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_test_seq_analyzer.sv
// Testbench for test_seq_analyzer: a responder process echoes programmed
// response words after a programmed latency, and a vector-level reference
// model derives the expected run statistics.
module tb_test_seq_analyzer;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam int CW    = 4;
    localparam int TMO   = 8;
    localparam int AW    = 6;
    localparam int WW    = DW + NCH * DW + NCH;

    logic              clk = 1'b0;
    logic              rst;
    logic              vec_wr_en;
    logic [AW-1:0]     vec_wr_addr;
    logic [WW-1:0]     vec_wr_data;
    logic              start;
    logic [AW:0]       num_vec;
    logic              abort;
    logic [DW-1:0]     stim_out;
    logic              stim_valid;
    logic [NCH*DW-1:0] resp_data;
    logic              resp_valid;
    logic              busy;
    logic              done;
    logic [NCH*CW-1:0] err_cnt;
    logic [CW-1:0]     timeout_cnt;
    logic [AW:0]       vec_cnt;
    logic [CW-1:0]     lat_min;
    logic [CW-1:0]     lat_max;
    logic [31:0]       lat_sum;
    logic              fail_valid;
    logic [AW-1:0]     fail_addr;

    test_seq_analyzer #(
        .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
        .start(start), .num_vec(num_vec), .abort(abort),
        .stim_out(stim_out), .stim_valid(stim_valid),
        .resp_data(resp_data), .resp_valid(resp_valid),
        .busy(busy), .done(done), .err_cnt(err_cnt), .timeout_cnt(timeout_cnt),
        .vec_cnt(vec_cnt), .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
        .fail_valid(fail_valid), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Vector table and per-vector DUT behaviour (r_lat < 0: never responds).
    logic [DW-1:0] v_stim [DEPTH];
    logic [DW-1:0] v_exp  [DEPTH][NCH];
    logic [NCH-1:0] v_mask [DEPTH];
    int            r_lat  [DEPTH];
    logic [DW-1:0] r_data [DEPTH][NCH];
    int            rsp_idx;

    // Reference results.
    int m_err [NCH];
    int m_tmo, m_cnt, m_min, m_max, m_sum, m_fv, m_fa;

    // Responder: the n-th stim_valid of a run answers with vector n's response.
    initial begin
        int idx;
        logic [NCH*DW-1:0] pk;
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (stim_valid) begin
                idx = rsp_idx;
                rsp_idx++;
                if (idx < DEPTH && r_lat[idx] >= 0) begin
                    for (int k = 0; k < r_lat[idx]; k++) begin
                        @(posedge clk); #1;
                    end
                    for (int c = 0; c < NCH; c++) pk[DW*c +: DW] = r_data[idx][c];
                    resp_data  = pk;
                    resp_valid = 1'b1;
                    @(posedge clk); #1;
                    resp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [WW-1:0] pack(int i);
        logic [WW-1:0] w;
        w = '0;
        w[DW-1:0] = v_stim[i];
        for (int c = 0; c < NCH; c++) w[DW + DW*c +: DW] = v_exp[i][c];
        w[DW + NCH*DW +: NCH] = v_mask[i];
        return w;
    endfunction

    // Every vector expects its stimulus on all channels and the DUT echoes it.
    task automatic setup_echo(input int lat);
        for (int i = 0; i < DEPTH; i++) begin
            v_stim[i] = DW'($urandom);
            v_mask[i] = '1;
            r_lat[i]  = lat;
            for (int c = 0; c < NCH; c++) begin
                v_exp[i][c]  = v_stim[i];
                r_data[i][c] = v_stim[i];
            end
        end
    endtask

    task automatic load_vecs(input int n);
        for (int i = 0; i < n; i++) begin
            vec_wr_en   = 1'b1;
            vec_wr_addr = AW'(i);
            vec_wr_data = pack(i);
            @(posedge clk); #1;
        end
        vec_wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        rsp_idx = 0;
        start   = 1'b1;
        num_vec = (AW + 1)'(n);
        @(posedge clk); #1;
        start     = 1'b0;
        vec_wr_en = 1'b0;
    endtask

    // Start a run and follow it to its end (bounded), then watch 3 more cycles.
    task automatic run(input int n, output int ndone, output int nstim, output logic [DW-1:0] fstim);
        int cyc;
        ndone = 0;
        nstim = 0;
        fstim = '0;
        pulse_start(n);
        cyc = 0;
        while (cyc < 3000) begin
            if (stim_valid) begin
                if (nstim == 0) fstim = stim_out;
                nstim++;
            end
            if (done) ndone++;
            if (!busy) break;
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        $display("run num_vec=%0d vec_cnt=%0d stims=%0d dones=%0d err=%h tmo=%0d lat=%0d/%0d/%0d fail=%0d@%0d",
                 n, vec_cnt, nstim, ndone, err_cnt, timeout_cnt, lat_min, lat_max, lat_sum, fail_valid, fail_addr);
    endtask

    // Vector-level model of a run's statistics.
    task automatic model(input int n);
        int nn;
        bit stop;
        bit vbad;
        nn = (n > DEPTH) ? DEPTH : n;
        for (int c = 0; c < NCH; c++) m_err[c] = 0;
        m_tmo = 0; m_cnt = 0; m_min = (1 << CW) - 1; m_max = 0; m_sum = 0; m_fv = 0; m_fa = 0;
        stop = 0;
        for (int i = 0; i < nn && !stop; i++) begin
            vbad = 0;
            m_cnt++;
            if (r_lat[i] < 0) begin
                if (m_tmo < 15) m_tmo++;
                vbad = 1;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (v_mask[i][c] && r_data[i][c] != v_exp[i][c]) begin
                        vbad = 1;
                        if (m_err[c] < 15) m_err[c]++;
                    end
                end
                if (r_lat[i] < m_min) m_min = r_lat[i];
                if (r_lat[i] > m_max) m_max = r_lat[i];
                m_sum += r_lat[i];
            end
            if (vbad && m_fv == 0) begin
                m_fv = 1;
                m_fa = i;
            end
`ifdef TSA_STOP_ON_FAIL_EN
            if (vbad) stop = 1;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy); end
        total++; if (done !== 1'b0 || stim_valid !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%0d%0d want=00", done, stim_valid); end
        total++; if (err_cnt !== '0 || timeout_cnt !== '0) begin bad++; $display("FAIL reset_cnts got=%h/%0d want=0/0", err_cnt, timeout_cnt); end
        total++; if (lat_min !== 4'hF || lat_max !== '0 || lat_sum !== '0) begin bad++; $display("FAIL reset_lat got=%0d/%0d/%0d want=15/0/0", lat_min, lat_max, lat_sum); end
        total++; if (vec_cnt !== '0 || fail_valid !== 1'b0 || fail_addr !== '0 || stim_out !== '0) begin bad++; $display("FAIL reset_misc got=%0d/%0d/%0d/%h want=0/0/0/0", vec_cnt, fail_valid, fail_addr, stim_out); end
    endtask

    task automatic test_pass();
        int nd, ns;
        logic [DW-1:0] fs;
        setup_echo(2);
        load_vecs(4);
        run(4, nd, ns, fs);
        total++; if (nd !== 1) begin bad++; $display("FAIL pass_done got=%0d want=1", nd); end
        total++; if (err_cnt !== '0 || fail_valid !== 1'b0) begin bad++; $display("FAIL pass_err got=%h/%0d want=0/0", err_cnt, fail_valid); end
        total++; if (vec_cnt !== 7'd4 || ns !== 4) begin bad++; $display("FAIL pass_cnt got=%0d/%0d want=4/4", vec_cnt, ns); end
        total++; if (lat_min !== 4'd2 || lat_max !== 4'd2 || lat_sum !== 32'd8) begin bad++; $display("FAIL pass_lat got=%0d/%0d/%0d want=2/2/8", lat_min, lat_max, lat_sum); end
        total++; if (fs !== v_stim[0]) begin bad++; $display("FAIL pass_stim got=%h want=%h", fs, v_stim[0]); end
    endtask

    task automatic test_mask();
        int nd, ns;
        logic [DW-1:0] fs;
        setup_echo(2);
        v_exp[1][2]  = 16'h1234;
        r_data[1][2] = 16'h1235;
        v_mask[1]    = 4'b1011;
        load_vecs(4);
        run(4, nd, ns, fs);
        total++; if (err_cnt !== '0 || fail_valid !== 1'b0) begin bad++; $display("FAIL mask_off got=%h/%0d want=0/0", err_cnt, fail_valid); end
        v_mask[1] = 4'b1111;
        load_vecs(4);
        run(4, nd, ns, fs);
        total++; if (err_cnt !== 16'h0100) begin bad++; $display("FAIL mask_on_err got=%h want=0100", err_cnt); end
        total++; if (fail_valid !== 1'b1 || fail_addr !== 6'd1) begin bad++; $display("FAIL mask_on_addr got=%0d@%0d want=1@1", fail_valid, fail_addr); end
`ifdef TSA_STOP_ON_FAIL_EN
        total++; if (vec_cnt !== 7'd2 || nd !== 1) begin bad++; $display("FAIL mask_on_cnt got=%0d/%0d want=2/1", vec_cnt, nd); end
`else
        total++; if (vec_cnt !== 7'd4 || nd !== 1) begin bad++; $display("FAIL mask_on_cnt got=%0d/%0d want=4/1", vec_cnt, nd); end
`endif
    endtask

    task automatic test_timeout();
        int nd, ns;
        logic [DW-1:0] fs;
        setup_echo(3);
        r_lat[2] = -1;
        load_vecs(3);
        run(3, nd, ns, fs);
        total++; if (timeout_cnt !== 4'd1 || nd !== 1) begin bad++; $display("FAIL tmo_cnt got=%0d/%0d want=1/1", timeout_cnt, nd); end
        total++; if (fail_valid !== 1'b1 || fail_addr !== 6'd2) begin bad++; $display("FAIL tmo_addr got=%0d@%0d want=1@2", fail_valid, fail_addr); end
        total++; if (vec_cnt !== 7'd3 || err_cnt !== '0) begin bad++; $display("FAIL tmo_vec got=%0d/%h want=3/0", vec_cnt, err_cnt); end
        total++; if (lat_min !== 4'd3 || lat_max !== 4'd3 || lat_sum !== 32'd6) begin bad++; $display("FAIL tmo_lat got=%0d/%0d/%0d want=3/3/6", lat_min, lat_max, lat_sum); end
    endtask

    task automatic test_saturation();
        int nd, ns;
        logic [DW-1:0] fs;
        setup_echo(1);
        for (int i = 0; i < 20; i++) r_data[i][0] = ~v_stim[i];
        load_vecs(20);
        run(20, nd, ns, fs);
`ifdef TSA_STOP_ON_FAIL_EN
        total++; if (err_cnt !== 16'h0001 || vec_cnt !== 7'd1) begin bad++; $display("FAIL sat_err got=%h/%0d want=0001/1", err_cnt, vec_cnt); end
`else
        total++; if (err_cnt !== 16'h000F || vec_cnt !== 7'd20) begin bad++; $display("FAIL sat_err got=%h/%0d want=000f/20", err_cnt, vec_cnt); end
`endif
        total++; if (fail_addr !== 6'd0 || fail_valid !== 1'b1 || nd !== 1) begin bad++; $display("FAIL sat_addr got=%0d@%0d/%0d want=1@0/1", fail_valid, fail_addr, nd); end
    endtask

    task automatic test_fail_position();
        int nd, ns;
        logic [DW-1:0] fs;
        setup_echo(1);
        r_data[3][1] = r_data[3][1] ^ 16'h0001;
        load_vecs(10);
        run(10, nd, ns, fs);
        total++; if (fail_addr !== 6'd3 || nd !== 1) begin bad++; $display("FAIL pos_addr got=%0d/%0d want=3/1", fail_addr, nd); end
`ifdef TSA_STOP_ON_FAIL_EN
        total++; if (vec_cnt !== 7'd4 || ns !== 4) begin bad++; $display("FAIL pos_cnt got=%0d/%0d want=4/4", vec_cnt, ns); end
`else
        total++; if (vec_cnt !== 7'd10 || ns !== 10) begin bad++; $display("FAIL pos_cnt got=%0d/%0d want=10/10", vec_cnt, ns); end
`endif
    endtask

    task automatic test_abort_restart();
        int ns, nd, cyc;
        setup_echo(1);
        r_lat[5] = -1;
        load_vecs(8);
        pulse_start(8);
        ns = 0; nd = 0; cyc = 0;
        while (ns < 6 && cyc < 500) begin
            if (stim_valid) ns++;
            if (done) nd++;
            if (ns < 6) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        total++; if (ns !== 6) begin bad++; $display("FAIL abort_reach got=%0d want=6", ns); end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (busy !== 1'b0 || vec_cnt !== 7'd5) begin bad++; $display("FAIL abort_state got=%0d/%0d want=0/5", busy, vec_cnt); end
        repeat (4) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        total++; if (nd !== 0 || fail_valid !== 1'b0) begin bad++; $display("FAIL abort_done got=%0d/%0d want=0/0", nd, fail_valid); end
        $display("abort vec_cnt=%0d busy=%0d", vec_cnt, busy);
        pulse_start(0);
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL zero_first got=%0d/%0d want=0/1", done, busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b1 || busy !== 1'b0 || vec_cnt !== '0 || lat_min !== 4'hF) begin bad++; $display("FAIL zero_done got=%0d/%0d/%0d/%0d want=1/0/0/15", done, busy, vec_cnt, lat_min); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%0d want=0", done); end
    endtask

    task automatic test_back_to_back();
        int nd, ns;
        logic [DW-1:0] fs;
        setup_echo(1);
        load_vecs(4);
        v_stim[0] = 16'hBEEF;
        for (int c = 0; c < NCH; c++) begin
            v_exp[0][c]  = 16'hBEEF;
            r_data[0][c] = 16'hBEEF;
        end
        // Write to address 0 in the same cycle as start.
        vec_wr_en   = 1'b1;
        vec_wr_addr = '0;
        vec_wr_data = pack(0);
        fork
            run(4, nd, ns, fs);
            begin
                repeat (5) @(posedge clk);
                #2;
                vec_wr_en   = 1'b1;
                vec_wr_addr = 6'd1;
                vec_wr_data = '1;
                @(posedge clk); #1;
                vec_wr_en = 1'b0;
            end
        join
        total++; if (fs !== 16'hBEEF || nd !== 1) begin bad++; $display("FAIL b2b_wr got=%h/%0d want=beef/1", fs, nd); end
        run(4, nd, ns, fs);
        total++; if (err_cnt !== '0 || fail_valid !== 1'b0 || vec_cnt !== 7'd4) begin bad++; $display("FAIL b2b_busy_wr got=%h/%0d/%0d want=0/0/4", err_cnt, fail_valid, vec_cnt); end
        total++; if (fs !== 16'hBEEF || nd !== 1 || ns !== 4) begin bad++; $display("FAIL b2b_second got=%h/%0d/%0d want=beef/1/4", fs, nd, ns); end
    endtask

    task automatic test_random();
        int nd, ns, n;
        logic [DW-1:0] fs;
        for (int it = 0; it < 6; it++) begin
            n = (it == 5) ? 70 : int'($urandom_range(1, 14));
            for (int i = 0; i < DEPTH; i++) begin
                v_stim[i] = DW'($urandom);
                v_mask[i] = NCH'($urandom);
                r_lat[i]  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
                for (int c = 0; c < NCH; c++) begin
                    v_exp[i][c]  = DW'($urandom);
                    r_data[i][c] = ($urandom_range(0, 4) == 0) ? (v_exp[i][c] ^ (DW'(1) << $urandom_range(0, DW - 1))) : v_exp[i][c];
                end
            end
            load_vecs(DEPTH);
            model(n);
            run(n, nd, ns, fs);
            for (int c = 0; c < NCH; c++) begin
                total++; if (err_cnt[CW*c +: CW] !== m_err[c][CW-1:0]) begin bad++; $display("FAIL rnd%0d_err%0d got=%0d want=%0d", it, c, err_cnt[CW*c +: CW], m_err[c]); end
            end
            total++; if (timeout_cnt !== m_tmo[CW-1:0] || vec_cnt !== m_cnt[AW:0] || ns !== m_cnt) begin bad++; $display("FAIL rnd%0d_cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", it, timeout_cnt, vec_cnt, ns, m_tmo, m_cnt, m_cnt); end
            total++; if (lat_min !== m_min[CW-1:0] || lat_max !== m_max[CW-1:0] || lat_sum !== m_sum) begin bad++; $display("FAIL rnd%0d_lat got=%0d/%0d/%0d want=%0d/%0d/%0d", it, lat_min, lat_max, lat_sum, m_min, m_max, m_sum); end
            total++; if (fail_valid !== m_fv[0] || fail_addr !== m_fa[AW-1:0] || nd !== 1) begin bad++; $display("FAIL rnd%0d_fail got=%0d@%0d/%0d want=%0d@%0d/1", it, fail_valid, fail_addr, nd, m_fv, m_fa); end
        end
    endtask

    task automatic test_async_reset();
        setup_echo(3);
        load_vecs(4);
        pulse_start(4);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || vec_cnt !== '0 || stim_out !== '0) begin bad++; $display("FAIL arst_now got=%0d/%0d/%h want=0/0/0", busy, vec_cnt, stim_out); end
        total++; if (lat_min !== 4'hF || lat_sum !== '0 || lat_max !== '0) begin bad++; $display("FAIL arst_lat got=%0d/%0d/%0d want=15/0/0", lat_min, lat_max, lat_sum); end
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || stim_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL arst_idle got=%0d/%0d/%0d want=0/0/0", busy, stim_valid, done); end
    endtask

    initial begin
        rst         = 1'b1;
        vec_wr_en   = 1'b0;
        vec_wr_addr = '0;
        vec_wr_data = '0;
        start       = 1'b0;
        num_vec     = '0;
        abort       = 1'b0;
        rsp_idx     = 0;
        test_reset();
        test_pass();
        test_mask();
        test_timeout();
        test_saturation();
        test_fail_position();
        test_abort_restart();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/test_seq_analyzer.md
Name: test_seq_analyzer

Overview:
Parametrised multi-channel test sequencer and response checker. It is the successor to the single-channel vector store plus result analyzer pair in the test system top.
- Holds DEPTH test vectors, each a stimulus, per-channel expected responses and a channel-enable mask.
- Plays vectors to the DUT path and compares NUM_CH response channels.
- Keeps saturating per-channel error counts, timeout count and latency min/max/sum statistics.
- Sits between ConfigParser (vector load, start) and the DUT I/O and ADC paths.

Parameters:
NUM_CH, 4, number of response channels compared per vector
DATA_W, 16, width of the stimulus and of each response channel
DEPTH, 1024, vector memory depth (power of 2); AW = clog2(DEPTH)
CNT_W, 16, width of each error counter and latency counter
TIMEOUT, 255, max cycles to wait for a response (1..2^CNT_W-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
vec_wr_en  in  1  vector memory write strobe
vec_wr_addr  in  AW  vector write address
vec_wr_data  in  DATA_W+NUM_CH*DATA_W+NUM_CH  {mask[NUM_CH], expected[NUM_CH*DATA_W], stim[DATA_W]}; ch0 = LSBs
start  in  1  one-cycle run request
num_vec  in  AW+1  vectors to run, from address 0 (clamped to DEPTH)
abort  in  1  stop run, return to IDLE
stim_out  out  DATA_W  stimulus to DUT
stim_valid  out  1  one-cycle strobe, stimulus is new
resp_data  in  NUM_CH*DATA_W  DUT responses
resp_valid  in  1  response strobe
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
err_cnt  out  NUM_CH*CNT_W  per-channel mismatch counts, saturating
timeout_cnt  out  CNT_W  vectors that timed out, saturating
vec_cnt  out  AW+1  vectors completed this run
lat_min  out  CNT_W  minimum response latency
lat_max  out  CNT_W  maximum response latency
lat_sum  out  32  sum of latencies, saturating at 2^32-1
fail_valid  out  1  a mismatch or timeout occurred this run
fail_addr  out  AW  address of first failing vector

Behaviour:
- Reset values:
  - All outputs 0, except lat_min = all-ones.
  - FSM in IDLE.
  - Memory contents undefined.
- Memory:
  - Synchronous write; synchronous read with 1-cycle latency.
  - Writes are ignored while busy.
- FSM states: IDLE, FETCH, DRIVE, WAIT, CHECK, DONE.
- IDLE:
  - start=1 clears all statistics (lat_min to all-ones), sets busy, loads addr=0, then goes to FETCH.
  - If start=1 and num_vec=0, the FSM goes straight to DONE.
  - start while busy is ignored.
- FETCH (1 cycle): issue memory read at addr.
- DRIVE (1 cycle):
  - Register stim_out from the read word and pulse stim_valid.
  - Clear lat counter to 0.
  - Go to WAIT.
- WAIT:
  - lat increments each cycle; resp_valid is sampled from the first WAIT cycle.
  - A response in the cycle after stim_valid gives latency 1.
  - resp_valid=1: capture resp_data and latency, go to CHECK.
  - lat reaches TIMEOUT with no response: timeout_cnt+1; if fail_valid=0, set fail_valid and fail_addr=addr; go to CHECK with no compare.
  - resp_valid in IDLE, FETCH, DRIVE or CHECK is ignored.
- CHECK (1 cycle):
  - For each channel i with mask[i]=1: mismatch if resp[i] != expected[i], and err_cnt[i] increments (saturating).
  - Masked channels are never counted.
  - Any mismatch with fail_valid=0 sets fail_valid and fail_addr.
  - Non-timeout vectors update lat_min, lat_max and lat_sum.
  - vec_cnt+1, addr+1.
  - If vec_cnt+1 == num_vec (value latched at start), go to DONE; else go to FETCH.
- DONE (1 cycle): pulse done, clear busy, go to IDLE. Statistics hold until the next start.
- abort: in any non-IDLE state, on the next edge go to IDLE and clear busy. No done pulse; statistics hold.
- Simultaneous events:
  - start and abort together in IDLE: abort wins.
  - vec_wr_en with start in IDLE: the write completes before the first FETCH.
- Throughput: a vector takes 3 + latency + 1 cycles minimum.
- Async rst mid-run returns everything to reset values immediately.

Optional Feature:
Macro: TSA_STOP_ON_FAIL_EN
- Defined: the first mismatch or timeout ends the run. CHECK (or a timed-out WAIT, after its CHECK) goes to DONE, and vec_cnt includes the failing vector.
- Undefined: the run always completes num_vec vectors.

Test Plan:
- Pass run: load 4 vectors, mask 4'b1111, expected = stim replicated; DUT echoes after 2 cycles; start num_vec=4 -> err_cnt all 0, vec_cnt=4, lat_min=lat_max=2, lat_sum=8, done once, fail_valid=0.
- Masked mismatch: vector 1 has ch2 expected 0x1234, response 0x1235, mask 4'b1011 -> err_cnt all 0. Repeat with mask 4'b1111 -> err_cnt[2]=1, fail_addr=1.
- Timeout: TIMEOUT=8, DUT never responds to vector 2 of 3 -> timeout_cnt=1, fail_addr=2, vec_cnt=3, latency stats exclude vector 2.
- Saturation: CNT_W=4, 20 vectors all mismatching on ch0 -> err_cnt[0]=15.
- Abort and restart: assert abort in WAIT of vector 5 -> busy=0, no done, vec_cnt=5. Then start num_vec=0 -> done 2 cycles after start, vec_cnt=0.
- TSA_STOP_ON_FAIL_EN build: 10 vectors, mismatch at vector 3 -> done, vec_cnt=4, fail_addr=3, no stim_valid for vector 4.
